// File: rtl/note_scroller_if.sv
// Note-event handshake between the music/keyboard producer and note_scroller.
//   nota_valid  producer -> scroller  note event offered
//   nota_pitch  producer -> scroller  pitch index 0..15 (15 = highest on screen)
//   nota_ready  scroller -> producer  slot free and accept allowed this cycle
interface note_scroller_if;
  logic       nota_valid;
  logic [3:0] nota_pitch;
  logic       nota_ready;

  modport master (output nota_valid, output nota_pitch, input nota_ready);
  modport slave  (input nota_valid, input nota_pitch, output nota_ready);
endinterface

// File: rtl/note_scroller.sv
// Scrolling-note layer for the object colour mux. Holds up to SLOTS notes,
// scrolls them left by SPEED on every frame_tick and reports per pixel whether
// a live note is hit and its colour.
//   clk, reset_n         clock, synchronous active-low reset
//   nota (slave)         note-event valid/ready handshake
//   frame_tick           one-cycle pulse per frame, moves all notes
//   video_on, pixel_x/y  current pixel
//   objeto_notas_on      registered: pixel hits a live note
//   color_notas          registered: colour of lowest-index hit note, else 0
//   slots_used           registered count of live slots
//   overflow             sticky: note offered while pool full
module note_scroller #(
  parameter int unsigned SLOTS     = 8,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned NOTE_W    = 16,
  parameter int unsigned NOTE_H    = 8,
  parameter int unsigned STAFF_TOP = 160,
  parameter int unsigned SPEED     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  note_scroller_if.slave   nota,
  input  logic             frame_tick,
  input  logic             video_on,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  output logic             objeto_notas_on,
  output logic [2:0]       color_notas,
  output logic [3:0]       slots_used,
  output logic             overflow
);

  localparam int unsigned XW   = 11;
  localparam int unsigned IDXW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CNTW = 4;

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [XW-1:0]    x_q     [SLOTS];
  logic [XW-1:0]    x_d     [SLOTS];
  logic [3:0]       pitch_q [SLOTS];
  logic [3:0]       pitch_d [SLOTS];

  logic             obj_q;
  logic [2:0]       color_q;
  logic [CNTW-1:0]  used_q;
  logic             ovf_q;

  logic             any_free_c;
  logic [IDXW-1:0]  free_idx_c;
  logic             ready_c;
  logic             accept_c;
  logic [CNTW-1:0]  cnt_d;
  logic             any_hit_c;
  logic [2:0]       hit_color_c;
  logic [XW-1:0]    px_c, py_c;

  function automatic logic [XW-1:0] note_ytop(input logic [3:0] p);
    return XW'(STAFF_TOP) + XW'(4'd15 - p) * XW'(NOTE_H / 2);
  endfunction

  // Pitch colour; pitches with low bits 000 map to white so no note is black.
  function automatic logic [2:0] slot_color(input logic [3:0] p);
    return (p[2:0] == 3'd0) ? 3'b111 : p[2:0];
  endfunction

  // Lowest-index free slot (descending scan so the lowest index is kept last).
  always_comb begin
    any_free_c = 1'b0;
    free_idx_c = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free_c = 1'b1;
        free_idx_c = IDXW'(i);
      end
    end
  end

  assign ready_c         = reset_n & any_free_c & ~frame_tick;
  assign accept_c        = nota.nota_valid & ready_c;
  assign nota.nota_ready = ready_c;

  // Slot next state: scroll on frame_tick, otherwise at most one accept.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    pitch_d = pitch_q;
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (frame_tick) begin
        if (valid_q[i]) begin
          if (x_q[i] < XW'(SPEED)) valid_d[i] = 1'b0;
          else                     x_d[i]     = x_q[i] - XW'(SPEED);
        end
      end else if (accept_c && (free_idx_c == IDXW'(i))) begin
        valid_d[i] = 1'b1;
        x_d[i]     = XW'(H_ACTIVE);
        pitch_d[i] = nota.nota_pitch;
      end
    end
  end

  // Live-slot count of the next state, so slots_used tracks valid_q exactly.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < int'(SLOTS); i++) cnt_d = cnt_d + CNTW'(valid_d[i]);
  end

  assign px_c = XW'(pixel_x);
  assign py_c = XW'(pixel_y);

  // Hit test against current slot state; lowest hitting index sets colour.
  always_comb begin
    any_hit_c   = 1'b0;
    hit_color_c = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          (px_c >= x_q[i]) && (px_c < x_q[i] + XW'(NOTE_W)) &&
          (py_c >= note_ytop(pitch_q[i])) &&
          (py_c < note_ytop(pitch_q[i]) + XW'(NOTE_H))) begin
        any_hit_c   = 1'b1;
        hit_color_c = slot_color(pitch_q[i]);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        x_q[i]     <= '0;
        pitch_q[i] <= '0;
      end
      obj_q   <= 1'b0;
      color_q <= '0;
      used_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      pitch_q <= pitch_d;
      obj_q   <= video_on & any_hit_c;
      color_q <= hit_color_c;
      used_q  <= cnt_d;
      if (nota.nota_valid && !any_free_c) ovf_q <= 1'b1;
    end
  end

  assign objeto_notas_on = obj_q;
  assign color_notas     = color_q;
  assign slots_used      = used_q;
  assign overflow        = ovf_q;

endmodule
